se_mixer_arbiter: RTL and testbench

//  Shares one speaker/tone output among NUM_SRC sound-effect generators (jump, hit, coin, ...).
//  - Each generator presents an enable and a 16-bit frequency in Hz.
//  - Fixed-priority arbitration: index 0 is the highest priority.
//  - Inserts a silent gap between consecutive effects.
//  - Synthesises the square wave for the winner with a phase accumulator.

---
 rtl/se_mixer_arbiter.sv | 152 +++++++++++++++
 tb/tb_se_mixer_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/se_mixer_arbiter.sv
// Fixed-priority sound-effect arbiter with inter-effect gap and phase-accumulator square wave.
// Define SE_MIXER_PREEMPT_EN to let a higher-priority request take over a playing effect.
module se_mixer_arbiter #(
    parameter int unsigned NUM_SRC     = 4,
    parameter int unsigned GAP_CYCLES  = 5000,
    parameter int unsigned PHASE_SCALE = 86
) (
    input  logic                   iClock,
    input  logic                   iResetN,
    input  logic [NUM_SRC-1:0]     iEnable,
    input  logic [16*NUM_SRC-1:0]  iFreq,
    input  logic                   iMute,
    output logic [NUM_SRC-1:0]     oGrant,
    output logic                   oEnable,
    output logic [15:0]            oFreq,
    output logic                   oWave
);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    localparam int unsigned CW        = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned GAP_LOAD  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [31:0] PHASE_INC = 32'(PHASE_SCALE);

    state_t          state_q, state_n;
    logic [2:0]      owner_q, owner_n;
    logic [NUM_SRC-1:0] grant_n;
    logic [15:0]     freq_q, freq_n;
    logic [31:0]     acc_q, acc_n;
    logic            wave_q, wave_n;
    logic [CW-1:0]   cnt_q, cnt_n;
    logic            any_req, own_en, start;
    logic [2:0]      first;

    function automatic logic [2:0] first_set(input logic [NUM_SRC-1:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int unsigned i = NUM_SRC; i > 0; i--) begin
            if (v[i-1]) idx = 3'(i - 1);
        end
        return idx;
    endfunction

    function automatic logic [NUM_SRC-1:0] onehot(input logic [2:0] idx);
        logic [NUM_SRC-1:0] oh;
        oh = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            oh[i] = (idx == 3'(i));
        end
        return oh;
    endfunction

    function automatic logic [15:0] sel_freq(input logic [2:0] idx,
                                             input logic [16*NUM_SRC-1:0] f);
        logic [15:0] r;
        r = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (idx == 3'(i)) r = f[16*i +: 16];
        end
        return r;
    endfunction

    assign any_req = |iEnable;
    assign own_en  = |(iEnable & oGrant);
    assign first   = first_set(iEnable);

    always_comb begin
        state_n = state_q;
        owner_n = owner_q;
        grant_n = oGrant;
        freq_n  = freq_q;
        acc_n   = acc_q;
        wave_n  = wave_q;
        cnt_n   = cnt_q;
        start   = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_req) start = 1'b1;
            end
            PLAY: begin
                if (!own_en) begin
                    // owner release takes precedence over any simultaneous higher-priority request
                    state_n = (GAP_CYCLES > 0) ? GAP : IDLE;
                    cnt_n   = CW'(GAP_LOAD);
                    owner_n = '0;
                    grant_n = '0;
                    freq_n  = '0;
                    acc_n   = '0;
                    wave_n  = 1'b0;
                end else begin
                    acc_n  = acc_q + 32'(freq_q) * PHASE_INC;
                    wave_n = (freq_q != '0) && acc_q[31];
                    freq_n = sel_freq(owner_q, iFreq);
`ifdef SE_MIXER_PREEMPT_EN
                    if (first < owner_q) begin
                        owner_n = first;
                        grant_n = onehot(first);
                        freq_n  = sel_freq(first, iFreq);
                    end
`endif
                end
            end
            GAP: begin
                // the last gap cycle arbitrates directly so the gap is exactly GAP_CYCLES long
                if (cnt_q == '0) begin
                    if (any_req) start = 1'b1;
                    else         state_n = IDLE;
                end else begin
                    cnt_n = cnt_q - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        if (start) begin
            state_n = PLAY;
            owner_n = first;
            grant_n = onehot(first);
            freq_n  = sel_freq(first, iFreq);
            acc_n   = '0;
            wave_n  = 1'b0;
        end
    end

    always_ff @(posedge iClock) begin
        if (!iResetN) begin
            state_q <= IDLE;
            owner_q <= '0;
            freq_q  <= '0;
            acc_q   <= '0;
            wave_q  <= 1'b0;
            cnt_q   <= '0;
            oGrant  <= '0;
            oEnable <= 1'b0;
            oFreq   <= '0;
            oWave   <= 1'b0;
        end else begin
            state_q <= state_n;
            owner_q <= owner_n;
            freq_q  <= freq_n;
            acc_q   <= acc_n;
            wave_q  <= wave_n;
            cnt_q   <= cnt_n;
            oGrant  <= grant_n;
            oEnable <= (state_n == PLAY) && !iMute;
            oFreq   <= iMute ? '0 : freq_n;
            oWave   <= wave_n && !iMute;
        end
    end

endmodule

// File: tb/tb_se_mixer_arbiter.sv
// Directed bench for se_mixer_arbiter (NUM_SRC=4, GAP_CYCLES=5, PHASE_SCALE=86).
module tb_se_mixer_arbiter;

    logic        iClock = 1'b0;
    logic        iResetN;
    logic [3:0]  iEnable;
    logic [63:0] iFreq;
    logic        iMute;
    logic [3:0]  oGrant;
    logic        oEnable;
    logic [15:0] oFreq;
    logic        oWave;

    int checks = 0;
    int errors = 0;

    se_mixer_arbiter #(.NUM_SRC(4), .GAP_CYCLES(5), .PHASE_SCALE(86)) dut (
        .iClock(iClock), .iResetN(iResetN), .iEnable(iEnable), .iFreq(iFreq),
        .iMute(iMute), .oGrant(oGrant), .oEnable(oEnable), .oFreq(oFreq), .oWave(oWave)
    );

    always #5 iClock = ~iClock;

    typedef struct {
        logic        rst_n;
        logic [3:0]  en;
        logic        mute;
        logic [3:0]  g;
        logic        e;
        logic [15:0] f;
    } vec_t;

    vec_t tbl [33];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge iClock);
        #1;
    endtask

    initial begin
        int per;
        int edges;
        int last;
        logic prev;

        // src3=400, src2=150, src1=440, src0=1000 Hz
        iFreq   = {16'd400, 16'd150, 16'd440, 16'd1000};
        iResetN = 1'b0;
        iEnable = 4'b1111;
        iMute   = 1'b0;

        tbl[0]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 16'd0};
        tbl[1]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 16'd0};
        tbl[2]  = '{1'b1, 4'b0100, 1'b0, 4'b0100, 1'b1, 16'd150};
        tbl[3]  = '{1'b1, 4'b0100, 1'b0, 4'b0100, 1'b1, 16'd150};
        tbl[4]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 16'd0};
        tbl[5]  = '{1'b1, 4'b0100, 1'b0, 4'b0000, 1'b0, 16'd0};
        tbl[6]  = '{1'b1, 4'b0100, 1'b0, 4'b0000, 1'b0, 16'd0};
        tbl[7]  = '{1'b1, 4'b0100, 1'b0, 4'b0000, 1'b0, 16'd0};
        tbl[8]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 16'd0};
        tbl[9]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 16'd0};
        tbl[10] = '{1'b1, 4'b0011, 1'b0, 4'b0001, 1'b1, 16'd1000};
        tbl[11] = '{1'b1, 4'b0011, 1'b0, 4'b0001, 1'b1, 16'd1000};
        tbl[12] = '{1'b1, 4'b0010, 1'b0, 4'b0000, 1'b0, 16'd0};
        tbl[13] = '{1'b1, 4'b0010, 1'b0, 4'b0000, 1'b0, 16'd0};
        tbl[14] = '{1'b1, 4'b0010, 1'b0, 4'b0000, 1'b0, 16'd0};
        tbl[15] = '{1'b1, 4'b0010, 1'b0, 4'b0000, 1'b0, 16'd0};
        tbl[16] = '{1'b1, 4'b0010, 1'b0, 4'b0000, 1'b0, 16'd0};
        tbl[17] = '{1'b1, 4'b0010, 1'b0, 4'b0010, 1'b1, 16'd440};
        tbl[18] = '{1'b1, 4'b1010, 1'b0, 4'b0010, 1'b1, 16'd440};
        tbl[19] = '{1'b1, 4'b0010, 1'b1, 4'b0010, 1'b0, 16'd0};
        tbl[20] = '{1'b1, 4'b0010, 1'b1, 4'b0010, 1'b0, 16'd0};
        tbl[21] = '{1'b1, 4'b0010, 1'b0, 4'b0010, 1'b1, 16'd440};
        tbl[22] = '{1'b1, 4'b0001, 1'b0, 4'b0000, 1'b0, 16'd0};
        tbl[23] = '{1'b1, 4'b0001, 1'b0, 4'b0000, 1'b0, 16'd0};
        tbl[24] = '{1'b1, 4'b0001, 1'b0, 4'b0000, 1'b0, 16'd0};
        tbl[25] = '{1'b1, 4'b0001, 1'b0, 4'b0000, 1'b0, 16'd0};
        tbl[26] = '{1'b1, 4'b0001, 1'b0, 4'b0000, 1'b0, 16'd0};
        tbl[27] = '{1'b1, 4'b0001, 1'b0, 4'b0001, 1'b1, 16'd1000};
        tbl[28] = '{1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0, 16'd0};
        tbl[29] = '{1'b1, 4'b0001, 1'b0, 4'b0001, 1'b1, 16'd1000};
        tbl[30] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 16'd0};
        tbl[31] = '{1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0, 16'd0};
        tbl[32] = '{1'b1, 4'b0100, 1'b0, 4'b0100, 1'b1, 16'd150};

        for (int i = 0; i < 33; i++) begin
            iResetN = tbl[i].rst_n;
            iEnable = tbl[i].en;
            iMute   = tbl[i].mute;
            step();
            check($sformatf("row%0d_grant", i), 32'(oGrant), 32'(tbl[i].g));
            check($sformatf("row%0d_enable", i), 32'(oEnable), 32'(tbl[i].e));
            check($sformatf("row%0d_freq", i), 32'(oFreq), 32'(tbl[i].f));
            if (!tbl[i].e) check($sformatf("row%0d_wave", i), 32'(oWave), 32'd0);
        end

        // live frequency tracking, then wave period at 20 kHz: 2^32/(20000*86) ~ 2497 cycles
        iResetN = 1'b0;
        iEnable = 4'b0000;
        step();
        iResetN = 1'b1;
        iEnable = 4'b0001;
        step();
        check("track_grant", 32'(oGrant), 32'b0001);
        check("track_freq_before", 32'(oFreq), 32'd1000);
        iFreq[15:0] = 16'd20000;
        step();
        check("track_freq_after", 32'(oFreq), 32'd20000);

        per   = -1;
        edges = 0;
        last  = 0;
        prev  = oWave;
        for (int c = 1; c <= 9000 && edges < 3; c++) begin
            step();
            if (oWave && !prev) begin
                edges++;
                if (edges == 3) per = c - last;
                last = c;
            end
            prev = oWave;
        end
        checks++;
        if (per < 2472 || per > 2522) begin
            errors++;
            $display("FAIL wave_period got %0d expected 2497 +/-25", per);
        end

        // higher-priority request while source 3 plays
        iResetN = 1'b0;
        iEnable = 4'b0000;
        iFreq[15:0] = 16'd1000;
        step();
        iResetN = 1'b1;
        iEnable = 4'b1000;
        step();
        check("pre_grant_src3", 32'(oGrant), 32'b1000);
        check("pre_freq_src3", 32'(oFreq), 32'd400);
        iEnable = 4'b1001;
        step();
`ifdef SE_MIXER_PREEMPT_EN
        check("preempt_grant", 32'(oGrant), 32'b0001);
        check("preempt_freq", 32'(oFreq), 32'd1000);
        check("preempt_enable", 32'(oEnable), 32'd1);
`else
        check("nopreempt_grant", 32'(oGrant), 32'b1000);
        check("nopreempt_freq", 32'(oFreq), 32'd400);
        check("nopreempt_enable", 32'(oEnable), 32'd1);
`endif
        step();
`ifdef SE_MIXER_PREEMPT_EN
        check("preempt_hold", 32'(oGrant), 32'b0001);
`else
        check("nopreempt_hold", 32'(oGrant), 32'b1000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
